// File: rtl/multicycle_controller.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/write-back
// strobes for the datapath, stalls on memory handshakes and counts retired instructions.
module multicycle_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  localparam logic [3:0] S_START   = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_WB_R    = 4'd4;
  localparam logic [3:0] S_EXEC_I  = 4'd5;
  localparam logic [3:0] S_WB_I    = 4'd6;
  localparam logic [3:0] S_ADDR    = 4'd7;
  localparam logic [3:0] S_MEM_RD  = 4'd8;
  localparam logic [3:0] S_WB_MEM  = 4'd9;
  localparam logic [3:0] S_MEM_WR  = 4'd10;
  localparam logic [3:0] S_BRANCH  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_ILLEGAL = 4'd13;

  logic [3:0]  r_state;
  logic [5:0]  r_op_q;
  logic [31:0] r_instret;
  logic [3:0]  w_next;
  logic        w_retire;
  logic        w_is_load;
  logic        w_byte;
  logic [1:0]  w_size;
  logic        w_unused_funct;

  // funct is consumed by the ALU decoder, not by this FSM
  assign w_unused_funct = ^funct;

  assign w_is_load = (r_op_q == 6'h23) || (r_op_q == 6'h20);
  assign w_byte    = (r_op_q == 6'h20) || (r_op_q == 6'h28);
  assign w_size    = w_byte ? 2'b00 : 2'b10;

  // Every return to FETCH retires an instruction, except the skip after ILLEGAL
  assign w_retire = (w_next == S_FETCH) && (r_state != S_START) && (r_state != S_ILLEGAL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_START;
      r_op_q    <= 6'd0;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next = S_START;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:                                w_next = S_EXEC_R;
          6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D:    w_next = S_EXEC_I;
          6'h23, 6'h20, 6'h2B, 6'h28:           w_next = S_ADDR;
          6'h04, 6'h05:                         w_next = S_BRANCH;
          6'h02:                                w_next = S_JUMP;
          default:                              w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:  w_next = S_WB_R;
      S_WB_R:    w_next = S_FETCH;
      S_EXEC_I:  w_next = S_WB_I;
      S_WB_I:    w_next = S_FETCH;
      S_ADDR:    w_next = w_is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM:  w_next = S_FETCH;
      S_MEM_WR:  w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_ILLEGAL: w_next = S_FETCH;
      default:   w_next = S_START;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_EXEC_R: alu_op = 2'b10;
      S_WB_R: begin
        alu_op    = 2'b10;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_EXEC_I: begin
        alu_src = 1'b1;
        alu_op  = 2'b11;
      end
      S_WB_I: begin
        alu_src   = 1'b1;
        alu_op    = 2'b11;
        reg_write = 1'b1;
      end
      S_ADDR: begin
        alu_src  = 1'b1;
        mem_size = w_size;
      end
      // Address strobes stay up through wait cycles so the address stays stable
      S_MEM_RD: begin
        alu_src  = 1'b1;
        mem_re   = 1'b1;
        mem_size = w_size;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        mem_size   = w_size;
      end
      S_MEM_WR: begin
        alu_src  = 1'b1;
        mem_we   = 1'b1;
        mem_size = w_size;
      end
      S_BRANCH: begin
        alu_op   = 2'b01;
        pc_src   = 2'b01;
        pc_write = (r_op_q == 6'h05) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver expands each instruction into its expected per-cycle
// output vectors; a monitor pops one vector per cycle and compares.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        mem_to_reg;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instret;

  multicycle_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .alu_op(alu_op), .mem_to_reg(mem_to_reg), .mem_re(mem_re),
    .mem_we(mem_we), .mem_size(mem_size), .illegal(illegal),
    .state(state), .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic [1:0]  pcs;
    logic        irw;
    logic        rdst;
    logic        rw;
    logic        asrc;
    logic [1:0]  aop;
    logic        m2r;
    logic        re;
    logic        we;
    logic [1:0]  msz;
    logic        ill;
    logic [31:0] ir;
  } vec_t;

  vec_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cnt   = 0;

  function automatic vec_t blank(input logic [3:0] s);
    vec_t v;
    v    = '0;
    v.st = s;
    v.ir = cnt;
    return v;
  endfunction

  function automatic vec_t actual();
    vec_t a;
    a.st = state;  a.pcw = pc_write; a.pcs = pc_src; a.irw = ir_write;
    a.rdst = reg_dst; a.rw = reg_write; a.asrc = alu_src; a.aop = alu_op;
    a.m2r = mem_to_reg; a.re = mem_re; a.we = mem_we; a.msz = mem_size;
    a.ill = illegal; a.ir = instret;
    return a;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic step(input vec_t v, input logic [5:0] op, input logic z, input logic mr);
    @(posedge clock);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    funct     = rop();
    q.push_back(v);
  endtask

  // Opcode is only meaningful in DECODE; it is scrambled elsewhere so the
  // latched copy, not the live input, must steer later states.
  task automatic do_instr(input logic [5:0] op, input logic z, input int waits);
    vec_t v;
    logic [1:0] sz;
    bit ret;
    sz  = (op == 6'h20 || op == 6'h28) ? 2'b00 : 2'b10;
    ret = 1;
    v = blank(4'd1); v.irw = 1; v.pcw = 1; step(v, rop(), rb(), rb());
    v = blank(4'd2); step(v, op, rb(), rb());
    case (op)
      6'h00: begin
        v = blank(4'd3); v.aop = 2'b10; step(v, rop(), rb(), rb());
        v = blank(4'd4); v.aop = 2'b10; v.rdst = 1; v.rw = 1; step(v, rop(), rb(), rb());
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin
        v = blank(4'd5); v.asrc = 1; v.aop = 2'b11; step(v, rop(), rb(), rb());
        v = blank(4'd6); v.asrc = 1; v.aop = 2'b11; v.rw = 1; step(v, rop(), rb(), rb());
      end
      6'h23, 6'h20: begin
        v = blank(4'd7); v.asrc = 1; v.msz = sz; step(v, rop(), rb(), rb());
        for (int i = 0; i <= waits; i++) begin
          v = blank(4'd8); v.asrc = 1; v.re = 1; v.msz = sz;
          step(v, rop(), rb(), (i == waits));
        end
        v = blank(4'd9); v.rw = 1; v.m2r = 1; v.msz = sz; step(v, rop(), rb(), rb());
      end
      6'h2B, 6'h28: begin
        v = blank(4'd7); v.asrc = 1; v.msz = sz; step(v, rop(), rb(), rb());
        for (int i = 0; i <= waits; i++) begin
          v = blank(4'd10); v.asrc = 1; v.we = 1; v.msz = sz;
          step(v, rop(), rb(), (i == waits));
        end
      end
      6'h04, 6'h05: begin
        v = blank(4'd11); v.aop = 2'b01; v.pcs = 2'b01;
        v.pcw = (op == 6'h04) ? z : ~z;
        step(v, rop(), z, rb());
      end
      6'h02: begin
        v = blank(4'd12); v.pcs = 2'b10; v.pcw = 1; step(v, rop(), rb(), rb());
      end
      default: begin
        v = blank(4'd13); v.ill = 1; step(v, rop(), rb(), rb());
        ret = 0;
      end
    endcase
    if (ret) cnt++;
  endtask

  task automatic store_reset();
    vec_t v;
    v = blank(4'd1); v.irw = 1; v.pcw = 1; step(v, rop(), rb(), rb());
    v = blank(4'd2); step(v, 6'h2B, rb(), rb());
    v = blank(4'd7); v.asrc = 1; v.msz = 2'b10; step(v, rop(), rb(), rb());
    v = blank(4'd10); v.asrc = 1; v.we = 1; v.msz = 2'b10; step(v, rop(), rb(), 1'b0);
    @(negedge clock);
    #1;
    chk("pre_rst_mem_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    cnt = 0;
    v = blank(4'd0); step(v, rop(), rb(), rb());
    v = blank(4'd0); step(v, rop(), rb(), rb());
    reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        vec_t e;
        vec_t a;
        e = q.pop_front();
        a = actual();
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle_vec st=%0d: got %h expected %h (instret got %0d exp %0d)",
                   e.st, a, e, a.ir, e.ir);
        end
      end
    end
  end

  initial begin
    logic [5:0] legal [12];
    vec_t v;
    legal = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
              6'h23, 6'h20, 6'h2B, 6'h28, 6'h04, 6'h02};
    for (int i = 0; i < 3; i++) begin
      v = blank(4'd0); step(v, rop(), rb(), rb());
    end
    v = blank(4'd0); step(v, rop(), rb(), rb());
    reset = 1'b1;

    do_instr(6'h00, 1'b0, 0);
    do_instr(6'h23, 1'b0, 2);
    do_instr(6'h04, 1'b1, 0);
    do_instr(6'h04, 1'b0, 0);
    do_instr(6'h05, 1'b1, 0);
    do_instr(6'h05, 1'b0, 0);
    do_instr(6'h3F, 1'b0, 0);
    do_instr(6'h20, 1'b0, 1);
    do_instr(6'h28, 1'b0, 0);
    store_reset();

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 11)];
      else if ($urandom_range(0, 1) == 1) op = 6'h05;
      else op = rop();
      do_instr(op, rb(), int'($urandom_range(0, 3)));
    end

    @(negedge clock);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
